dsp_div_seq: RTL and testbench

- Sequential RV32M divider (DIV, DIVU, REM, REMU) for sail-core, placed beside the ALU.
- Performs restoring division, one quotient bit per cycle.
- Each trial subtraction is sent to the existing DSP-based 32-bit subtractor: this block drives its A/B operands and consumes its difference and carry-out in the same cycle (that subtractor is unregistered).
- It sits directly upstream of the subtractor and directly downstream of it.

---
 rtl/dsp_div_seq.sv | 112 +++++++++++
 tb/tb_dsp_div_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dsp_div_seq.sv
// Sequential RV32M divider (DIV/DIVU/REM/REMU): restoring division, one quotient
// bit per cycle, with trial subtractions done by an external combinational subtractor.
module dsp_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] sub_a,
  output logic [XLEN-1:0] sub_b,
  input  logic [XLEN-1:0] sub_diff,
  input  logic            sub_carry
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t          r_state, w_next;
  logic [XLEN-1:0] r_rem, r_quo, r_div, r_orig, r_result;
  logic [4:0]      r_cnt;
  logic [1:0]      r_op;
  logic            r_neg_q, r_neg_r, r_dz, r_busy, r_done;

  logic            w_signed, w_a_neg, w_b_neg, w_msb, w_qbit;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_shift, w_quot, w_remd;

  // op[0]=0 selects the signed variants (DIV, REM)
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & dividend[XLEN-1];
  assign w_b_neg  = w_signed & divisor[XLEN-1];
  assign w_a_mag  = w_a_neg ? -dividend : dividend;
  assign w_b_mag  = w_b_neg ? -divisor  : divisor;

  // msb is bit 32 of the shifted partial remainder; when set the trial always succeeds
  assign w_shift = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
  assign w_msb   = r_rem[XLEN-1];
  assign w_qbit  = w_msb | sub_carry;

  assign w_quot = r_dz ? '1     : (r_neg_q ? -r_quo : r_quo);
  assign w_remd = r_dz ? r_orig : (r_neg_r ? -r_rem : r_rem);

  assign sub_a  = (r_state == S_RUN) ? w_shift : '0;
  assign sub_b  = (r_state == S_RUN) ? r_div   : '0;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = (divisor == '0) ? S_FIX : S_RUN;
      S_RUN:  if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_orig   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_op    <= op;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_dz    <= (divisor == '0);
          r_orig  <= dividend;
          r_div   <= w_b_mag;
          r_quo   <= w_a_mag;
          r_rem   <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
        S_RUN: begin
          r_rem <= w_qbit ? sub_diff : w_shift;
          r_quo <= {r_quo[XLEN-2:0], w_qbit};
          r_cnt <= r_cnt + 5'd1;
        end
        S_FIX: begin
          r_result <= r_op[1] ? w_remd : w_quot;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_div_seq.sv
// Directed bench for dsp_div_seq; models the external subtractor combinationally.
module tb_dsp_div_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] result, sub_a, sub_b, sub_diff;
  logic        sub_carry;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  dsp_div_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result),
    .sub_a(sub_a), .sub_b(sub_b), .sub_diff(sub_diff), .sub_carry(sub_carry)
  );

  assign sub_diff  = sub_a - sub_b;
  assign sub_carry = (sub_a >= sub_b);

  always #5 clk = ~clk;

  // Issue one op and wait (bounded) for done; lat = edges after the accepting edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit ok);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; ok = 1'b0; res = 'x;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); lat++; #1;
      if (done) begin ok = 1'b1; res = result; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (sub_a !== 32'h0 || sub_b !== 32'h0)
      begin errors++; $display("FAIL reset_sub got=%h/%h exp=0/0", sub_a, sub_b); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [31:0] r; int lat; bit ok;
    @(negedge clk);
    start = 1'b1; op = DIVU; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divu_busy got=%b exp=1", busy); end
    checks++; if (sub_b !== 32'd7) begin errors++; $display("FAIL divu_sub_b got=%h exp=7", sub_b); end
    lat = 0; ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); lat++; #1;
      if (done) begin ok = 1'b1; r = result; break; end
    end
    checks++; if (!ok || r !== 32'd14) begin errors++; $display("FAIL divu_100_7 got=%h ok=%0d exp=0000000e", r, ok); end
    checks++; if (lat != 33) begin errors++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu_busy_end got=%b exp=0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%b exp=0", done); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL result_hold got=%h exp=0000000e", result); end
    run_op(REMU, 32'd100, 32'd7, r, lat, ok);
    checks++; if (!ok || r !== 32'd2) begin errors++; $display("FAIL remu_100_7 got=%h ok=%0d exp=00000002", r, ok); end
  endtask

  task automatic test_signed();
    logic [31:0] r; int lat; bit ok;
    run_op(DIV, 32'hFFFFFFF9, 32'd2, r, lat, ok);
    checks++; if (!ok || r !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_m7_2 got=%h ok=%0d exp=fffffffd", r, ok); end
    run_op(REM, 32'hFFFFFFF9, 32'd2, r, lat, ok);
    checks++; if (!ok || r !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_m7_2 got=%h ok=%0d exp=ffffffff", r, ok); end
    run_op(DIV, 32'd7, 32'hFFFFFFFE, r, lat, ok);
    checks++; if (!ok || r !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_7_m2 got=%h ok=%0d exp=fffffffd", r, ok); end
    run_op(REM, 32'd7, 32'hFFFFFFFE, r, lat, ok);
    checks++; if (!ok || r !== 32'd1) begin errors++; $display("FAIL rem_7_m2 got=%h ok=%0d exp=00000001", r, ok); end
  endtask

  task automatic test_msb();
    logic [31:0] r; int lat; bit ok;
    run_op(DIVU, 32'hFFFFFFFF, 32'h80000001, r, lat, ok);
    checks++; if (!ok || r !== 32'd1) begin errors++; $display("FAIL divu_msb got=%h ok=%0d exp=00000001", r, ok); end
    run_op(REMU, 32'hFFFFFFFF, 32'h80000001, r, lat, ok);
    checks++; if (!ok || r !== 32'h7FFFFFFE) begin errors++; $display("FAIL remu_msb got=%h ok=%0d exp=7ffffffe", r, ok); end
  endtask

  task automatic test_div_zero();
    logic [31:0] r; int lat; bit ok;
    run_op(DIV, 32'h12345678, 32'h0, r, lat, ok);
    checks++; if (!ok || r !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_dz got=%h ok=%0d exp=ffffffff", r, ok); end
    checks++; if (lat != 1) begin errors++; $display("FAIL div_dz_latency got=%0d exp=1", lat); end
    run_op(DIVU, 32'h12345678, 32'h0, r, lat, ok);
    checks++; if (!ok || r !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_dz got=%h ok=%0d exp=ffffffff", r, ok); end
    run_op(REM, 32'h12345678, 32'h0, r, lat, ok);
    checks++; if (!ok || r !== 32'h12345678) begin errors++; $display("FAIL rem_dz got=%h ok=%0d exp=12345678", r, ok); end
    checks++; if (lat != 1) begin errors++; $display("FAIL rem_dz_latency got=%0d exp=1", lat); end
    run_op(REM, 32'h87654321, 32'h0, r, lat, ok);
    checks++; if (!ok || r !== 32'h87654321) begin errors++; $display("FAIL rem_dz_neg got=%h ok=%0d exp=87654321", r, ok); end
    run_op(REMU, 32'h12345678, 32'h0, r, lat, ok);
    checks++; if (!ok || r !== 32'h12345678) begin errors++; $display("FAIL remu_dz got=%h ok=%0d exp=12345678", r, ok); end
  endtask

  task automatic test_overflow();
    logic [31:0] r; int lat; bit ok;
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, r, lat, ok);
    checks++; if (!ok || r !== 32'h80000000) begin errors++; $display("FAIL div_ovf got=%h ok=%0d exp=80000000", r, ok); end
    run_op(REM, 32'h80000000, 32'hFFFFFFFF, r, lat, ok);
    checks++; if (!ok || r !== 32'h0) begin errors++; $display("FAIL rem_ovf got=%h ok=%0d exp=00000000", r, ok); end
  endtask

  task automatic test_ignore_start();
    logic [31:0] r; int lat; bit ok;
    @(negedge clk);
    start = 1'b1; op = DIVU; dividend = 32'd1000; divisor = 32'd10;
    @(posedge clk); #1; start = 1'b0;
    lat = 0; ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k == 9) begin
        start = 1'b1; op = REMU; dividend = 32'd55; divisor = 32'd3;
      end
      @(posedge clk); lat++; #1;
      start = 1'b0;
      if (done) begin ok = 1'b1; r = result; break; end
    end
    checks++; if (!ok || r !== 32'd100) begin errors++; $display("FAIL ignore_start_result got=%h ok=%0d exp=00000064", r, ok); end
    checks++; if (lat != 33) begin errors++; $display("FAIL ignore_start_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat; bit ok;
    run_op(DIVU, 32'd100, 32'd7, r, lat, ok);
    // done is high now: issue the next op in this same cycle
    start = 1'b1; op = DIV; dividend = 32'hFFFFFFF9; divisor = 32'd2;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL b2b_hold got=%h exp=0000000e", result); end
    lat = 0; ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); lat++; #1;
      if (done) begin ok = 1'b1; r = result; break; end
    end
    checks++; if (!ok || r !== 32'hFFFFFFFD || lat != 33)
      begin errors++; $display("FAIL b2b_second got=%h lat=%0d ok=%0d exp=fffffffd lat=33", r, lat, ok); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    start = 1'b1; op = DIVU; dividend = 32'd500; divisor = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midreset_result got=%h exp=0", result); end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midreset_no_done got=1 exp=0"); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_msb();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
